// File: rtl/uart_bus_master.sv
// 8N1 UART command decoder acting as a bus initiator: 'W'/'R' + little-endian address
// (+ data) frames become single word accesses; read data or 'K' goes back on TX.
`timescale 1ns/1ps
module uart_bus_master #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_mem_valid,
  output logic        o_mem_instr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;
  p_state_t  r_p_state, w_p_next;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_done, r_rx_ferr;
  logic          w_rx_tick, w_rx_half, w_rx_fall, w_rx_ok, w_rx_bad;

  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_uart_tx;
  logic          w_tx_tick, w_tx_end, w_tx_start;
  logic [7:0]    w_tx_byte;
  logic [31:0]   w_tx_word;
  logic [1:0]    w_tx_sel;

  logic [1:0]    r_idx;
  logic          r_is_write;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic          r_mem_valid;
  logic [31:0]   r_mem_addr, r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic          w_byte_take, w_bus_go, w_resp_last;
  logic [31:0]   w_addr_full, w_wdata_full;

  assign w_rx_tick = (r_rx_cnt == BIT_LAST);
  assign w_rx_half = (r_rx_cnt == HALF_LAST);
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_tx_tick = (r_tx_cnt == BIT_LAST);
  assign w_tx_end  = (r_tx_state == TX_STOP) && w_tx_tick;

  assign o_uart_tx   = r_uart_tx;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_instr = 1'b0;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

  // Receiver next state; only a true falling edge starts a frame, so a line stuck low is ignored.
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_ok   = 1'b0;
    w_rx_bad  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_next = RX_IDLE;
          w_rx_ok   = r_rx_s2;
          w_rx_bad  = ~r_rx_s2;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Receiver state, synchronizer, baud counter and shift register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= {CW{1'b0}};
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_s1    <= i_uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      if ((r_rx_state == RX_IDLE) || (w_rx_next != r_rx_state) || w_rx_tick) r_rx_cnt <= {CW{1'b0}};
      else r_rx_cnt <= r_rx_cnt + CW'(1);
      if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end else if (r_rx_state != RX_DATA) begin
        r_rx_bit   <= 3'd0;
      end
      r_rx_done <= w_rx_ok;
      r_rx_ferr <= w_rx_bad;
    end
  end

  // Transmitter next state; a start request in the stop-bit tick chains bytes back to back.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_start) w_tx_next = TX_START;
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick) w_tx_next = w_tx_start ? TX_START : TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // Transmitter state, bit timer and serial output register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= {CW{1'b0}};
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      if ((r_tx_state == TX_IDLE) || w_tx_tick) r_tx_cnt <= {CW{1'b0}};
      else r_tx_cnt <= r_tx_cnt + CW'(1);
      if (w_tx_start) begin
        r_uart_tx  <= 1'b0;
        r_tx_shift <= w_tx_byte;
        r_tx_bit   <= 3'd0;
      end else if (w_tx_tick && (r_tx_state == TX_START)) begin
        r_uart_tx  <= r_tx_shift[0];
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      end else if (w_tx_tick && (r_tx_state == TX_DATA)) begin
        r_uart_tx  <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[0];
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 3'd1;
      end else if (w_tx_end) begin
        r_uart_tx  <= 1'b1;
      end else begin
        r_uart_tx  <= r_uart_tx;
      end
    end
  end

  // Parser next state, bus launch and response byte selection.
  always_comb begin
    w_p_next     = r_p_state;
    w_tx_start   = 1'b0;
    w_byte_take  = r_rx_done && ((r_p_state == P_ADDR) || (r_p_state == P_DATA));
    w_resp_last  = r_is_write || (r_idx == 2'd3);
    w_addr_full  = (r_p_state == P_ADDR) ? {r_rx_shift, r_addr[23:0]} : r_addr;
    w_wdata_full = {r_rx_shift, r_wdata[23:0]};
    case (r_p_state)
      P_CMD:  if (r_rx_done && ((r_rx_shift == 8'h57) || (r_rx_shift == 8'h52))) w_p_next = P_ADDR;
      P_ADDR: begin
        if (r_rx_ferr) w_p_next = P_CMD;
        else if (r_rx_done && (r_idx == 2'd3)) w_p_next = r_is_write ? P_DATA : P_BUS;
      end
      P_DATA: begin
        if (r_rx_ferr) w_p_next = P_CMD;
        else if (r_rx_done && (r_idx == 2'd3)) w_p_next = P_BUS;
      end
      P_BUS: begin
        if (r_mem_valid && i_mem_ready) begin
          w_p_next   = P_RESP;
          w_tx_start = 1'b1;
        end
      end
      P_RESP: begin
        if (w_tx_end) begin
          if (w_resp_last) w_p_next = P_CMD;
          else w_tx_start = 1'b1;
        end
      end
      default: w_p_next = P_CMD;
    endcase
    w_bus_go  = (r_p_state != P_BUS) && (w_p_next == P_BUS);
    w_tx_word = (r_p_state == P_BUS) ? i_mem_rdata : r_rdata;
    w_tx_sel  = (r_p_state == P_BUS) ? 2'd0 : (r_idx + 2'd1);
    if (r_is_write) w_tx_byte = 8'h4B;
    else w_tx_byte = w_tx_word[{w_tx_sel, 3'b000} +: 8];
  end

  // Parser state, assembled address/data and the registered bus request.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_p_state   <= P_CMD;
      r_idx       <= 2'd0;
      r_is_write  <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_rdata     <= 32'h0000_0000;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'h0;
    end else begin
      r_p_state <= w_p_next;
      if (w_p_next == P_CMD) r_idx <= 2'd0;
      else if (w_byte_take || ((r_p_state == P_RESP) && w_tx_end)) r_idx <= r_idx + 2'd1;
      if ((r_p_state == P_CMD) && (w_p_next == P_ADDR)) r_is_write <= (r_rx_shift == 8'h57);
      if (w_byte_take && (r_p_state == P_ADDR)) r_addr[{r_idx, 3'b000} +: 8] <= r_rx_shift;
      if (w_byte_take && (r_p_state == P_DATA)) r_wdata[{r_idx, 3'b000} +: 8] <= r_rx_shift;
      if (w_bus_go) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= {w_addr_full[31:2], 2'b00};
        r_mem_wstrb <= r_is_write ? 4'hF : 4'h0;
        if (r_is_write) r_mem_wdata <= w_wdata_full;
      end else if ((r_p_state == P_BUS) && r_mem_valid && i_mem_ready) begin
        r_mem_valid <= 1'b0;
        r_rdata     <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus requests and TX bytes,
// independent monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_bus_master;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        tx, valid, instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  uart_bus_master #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_uart_rx(rx), .o_uart_tx(tx),
    .o_mem_valid(valid), .o_mem_instr(instr), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .o_mem_wstrb(wstrb), .i_mem_rdata(rdata), .i_mem_ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = 32'h0;
  bit          resp_pending = 1'b0;
  bit          stray_req = 1'b0;
  int          fall_cyc = 0;
  bit          resp_first = 1'b0;
  logic        pv = 1'b0;
  logic [31:0] la, ld;
  logic [3:0]  ls;
  logic        tx_prev = 1'b1;
  logic        samples [0:10*CPB-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] d, input int dly);
    bus_t e;
    e.addr = {a[31:2], 2'b00}; e.wdata = 32'h0; e.wstrb = 4'h0; e.chk_wdata = 1'b0;
    e.delay = dly; e.rdata = d;
    exp_bus.push_back(e);
    for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input int dly);
    bus_t e;
    e.addr = {a[31:2], 2'b00}; e.wdata = d; e.wstrb = 4'hF; e.chk_wdata = 1'b1;
    e.delay = dly; e.rdata = 32'hFFFF_FFFF;
    exp_bus.push_back(e);
    exp_tx.push_back(8'h4B);
  endtask

  task automatic drain();
    int t = 0;
    while (((exp_bus.size() != 0) || (exp_tx.size() != 0)) && (t < 20000)) begin
      wait_cyc(1);
      t++;
    end
    chk(t < 20000, "drain_timeout", 32'(exp_tx.size()), 32'h0);
    wait_cyc(12 * CPB);
  endtask

  // Bus monitor: pops on each new request, checks hold-stability while valid stays high.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (valid && !pv) begin
        if (exp_bus.size() == 0) begin
          chk(1'b0, "unexpected_bus", addr, 32'h0);
          cur_delay = 0; cur_rdata = 32'h0;
        end else begin
          e = exp_bus.pop_front();
          chk(addr == e.addr, "bus_addr", addr, e.addr);
          chk(wstrb == e.wstrb, "bus_wstrb", 32'(wstrb), 32'(e.wstrb));
          chk(instr == 1'b0, "bus_instr", 32'(instr), 32'h0);
          if (e.chk_wdata) chk(wdata == e.wdata, "bus_wdata", wdata, e.wdata);
          cur_delay = e.delay; cur_rdata = e.rdata;
        end
        resp_pending = 1'b1;
        la = addr; ld = wdata; ls = wstrb;
      end else if (valid && pv) begin
        chk((addr == la) && (wdata == ld) && (wstrb == ls) && (instr == 1'b0), "bus_stable", addr, la);
      end
      if (!valid && pv) begin
        fall_cyc = cyc;
        resp_first = 1'b1;
      end
      pv = valid;
    end
  end

  // Responder: completes each request after its scripted delay; also issues stray ready pulses.
  initial begin
    forever begin
      wait_cyc(1);
      if (stray_req) begin
        stray_req = 1'b0;
        ready = 1'b1; rdata = 32'h5555_AAAA;
        wait_cyc(1);
        ready = 1'b0; rdata = 32'hFFFF_FFFF;
      end else if (resp_pending) begin
        resp_pending = 1'b0;
        if (cur_delay > 0) wait_cyc(cur_delay);
        ready = 1'b1; rdata = cur_rdata;
        wait_cyc(1);
        ready = 1'b0; rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // TX monitor: records each frame, checks both ends of every bit cell and the byte value.
  initial begin
    logic [7:0] b;
    bit ok;
    int start_cyc;
    forever begin
      @(negedge clk);
      if (tx_prev && !tx) begin
        start_cyc = cyc;
        samples[0] = tx;
        for (int k = 1; k < 10 * CPB; k++) begin
          @(negedge clk);
          samples[k] = tx;
        end
        ok = (samples[0] == 1'b0) && (samples[9*CPB] == 1'b1);
        for (int j = 0; j < 10; j++)
          if (samples[j*CPB] != samples[j*CPB + CPB - 1]) ok = 1'b0;
        for (int j = 0; j < 8; j++) b[j] = samples[(j+1)*CPB];
        if (resp_first) begin
          chk((start_cyc - fall_cyc) <= 2, "tx_latency", 32'(start_cyc - fall_cyc), 32'd2);
          resp_first = 1'b0;
        end
        if (exp_tx.size() == 0) chk(1'b0, "unexpected_tx", 32'(b), 32'h0);
        else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          chk(ok && (b == e), "tx_byte", {23'h0, ok, b}, {24'h1, e});
        end
      end
      tx_prev = tx;
    end
  end

  initial begin
    wait_cyc(5);
    chk(tx == 1'b1, "reset_tx", 32'(tx), 32'h1);
    chk(valid == 1'b0, "reset_valid", 32'(valid), 32'h0);
    chk(wstrb == 4'h0, "reset_wstrb", 32'(wstrb), 32'h0);
    chk(addr == 32'h0, "reset_addr", addr, 32'h0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Reset pulse in the middle of an incoming 'W' frame.
    fork
      send_byte(8'h57, 1'b1);
      begin
        wait_cyc(CPB + 2);
        rst_n = 1'b0;
        #1;
        chk(tx == 1'b1, "midreset_tx", 32'(tx), 32'h1);
        chk(valid == 1'b0, "midreset_valid", 32'(valid), 32'h0);
        chk(wstrb == 4'h0, "midreset_wstrb", 32'(wstrb), 32'h0);
        wait_cyc(5);
        rst_n = 1'b1;
      end
    join
    wait_cyc(16 * CPB);
    expect_read(32'h0000_0100, 32'hCAFE_F00D, 2);
    send_byte(8'h52, 1'b1); send_word(32'h0000_0100);
    drain();

    // Word write, responder ready after 3 cycles.
    expect_write(32'h8000_0010, 32'hDEAD_BEEF, 3);
    send_byte(8'h57, 1'b1); send_word(32'h8000_0010); send_word(32'hDEAD_BEEF);
    drain();

    // Word read returning 0x12345678.
    expect_read(32'h8000_0004, 32'h1234_5678, 1);
    send_byte(8'h52, 1'b1); send_word(32'h8000_0004);
    drain();

    // Framing error on the command byte, then a read with the low address bits masked.
    send_byte(8'h52, 1'b0);
    wait_cyc(4 * CPB);
    expect_read(32'h0000_0001, 32'h0BAD_F00D, 0);
    send_byte(8'h52, 1'b1); send_word(32'h0000_0001);
    drain();

    // Unknown command bytes and a stray ready are ignored; a write follows.
    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b1);
    stray_req = 1'b1;
    wait_cyc(4 * CPB);
    expect_write(32'h0000_000C, 32'h4433_2211, 0);
    send_byte(8'h57, 1'b1); send_word(32'h0000_000C); send_word(32'h4433_2211);
    drain();

    // Slow responder; bytes arriving while the bus is busy are dropped.
    expect_read(32'h2000_0008, 32'hA5A5_5A5A, 1000);
    send_byte(8'h52, 1'b1); send_word(32'h2000_0008);
    send_byte(8'h57, 1'b1); send_word(32'h0403_0201);
    drain();
    expect_read(32'h0000_0040, 32'h0102_0304, 0);
    send_byte(8'h52, 1'b1); send_word(32'h0000_0040);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
